// File: rtl/pm_axi_ddr_writer.sv
// pm_axi_ddr_writer: single-beat AXI4 write master that stores one 64-bit
// postmortem word in PS DDR per request and answers each word with a done pulse.
module pm_axi_ddr_writer #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [39:0] i_addr,
    input  logic [63:0] i_data,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_timeout,
    input  logic        i_err_clr,
    output logic [2:0]  o_state,
    output logic [39:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic [7:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SETL = 3'd1,
        S_ADDR = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    localparam logic [3:0]  SETL_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  setl_q, setl_d;
    logic [15:0] tmo_q, tmo_d;
    logic [39:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        err_q, err_d;
    logic        tmof_q, tmof_d;
    logic        err_set, tmo_set;

    // Next-state logic: request sequencing, AXI handshakes, timeout and sticky flags
    always_comb begin
        state_d   = state_q;
        setl_d    = setl_q;
        tmo_d     = tmo_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        err_set   = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_SETL;
                    setl_d  = '0;
                end
            end
            S_SETL: begin
                // handler updates addr/data a cycle after raising start; wait it out
                if (!i_start) begin
                    state_d = S_IDLE;
                end else if (setl_q == SETL_LAST) begin
                    awaddr_d  = i_addr & ~40'h7;
                    wdata_d   = i_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_ADDR;
                end else begin
                    setl_d = setl_q + 4'd1;
                end
            end
            S_ADDR: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = S_RESP;
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = S_DONE;
                    // SLVERR/DECERR both have bit 1 set
                    err_set = |(m_axi_bresp & 2'b10);
                end
            end
            S_DONE:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // timeout is only flagged; an AXI write can never be abandoned
        if (state_q == S_ADDR || state_q == S_RESP) begin
            if (tmo_q != 16'hFFFF) begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_d == TMO_LIM) tmo_set = 1'b1;
            end
        end
        err_d  = err_set | (err_q & ~i_err_clr);
        tmof_d = tmo_set | (tmof_q & ~i_err_clr);
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            setl_q    <= '0;
            tmo_q     <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            tmof_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            setl_q    <= setl_d;
            tmo_q     <= tmo_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            err_q     <= err_d;
            tmof_q    <= tmof_d;
        end
    end

    assign o_done        = (state_q == S_DONE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_err         = err_q;
    assign o_timeout     = tmof_q;
    assign o_state       = state_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 8'hFF;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_RESP);

endmodule

// File: tb/tb_pm_axi_ddr_writer.sv
// Testbench for pm_axi_ddr_writer: handler model, configurable AXI slave
// and an address/data scoreboard checked at each AW/W handshake.
module tb_pm_axi_ddr_writer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [39:0] i_addr = '0;
    logic [63:0] i_data = '0;
    logic        i_err_clr = 1'b0;
    logic        o_done, o_busy, o_err, o_timeout;
    logic [2:0]  o_state;
    logic [39:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    pm_axi_ddr_writer #(.SETTLE_CYC(2), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_addr(i_addr),
        .i_data(i_data), .o_done(o_done), .o_busy(o_busy), .o_err(o_err),
        .o_timeout(o_timeout), .i_err_clr(i_err_clr), .o_state(o_state),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // scoreboard and slave configuration
    logic [39:0] aw_q[$];
    logic [63:0] w_q[$];
    int   aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] bresp_sel = 2'b00;
    int   aw_cnt = 0, w_cnt = 0, b_req = 0, b_pend = 0;
    int   aw_wait = 0, w_wait = 0, b_wait = 0;
    bit   prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;

    // AXI slave: decides ready/valid at negedge, so each handshake is known before its edge
    always @(negedge i_clk) begin
        if (!i_rst) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; b_pend = 0;
            b_req = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
            prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
        end else begin
            if (prev_awv && !prev_awr) begin
                n_cmp++;
                if (m_axi_awvalid !== 1'b1) begin
                    n_bad++; $display("FAIL awvalid_hold: awvalid=%b required 1", m_axi_awvalid);
                end
            end
            if (prev_wv && !prev_wr) begin
                n_cmp++;
                if (m_axi_wvalid !== 1'b1) begin
                    n_bad++; $display("FAIL wvalid_hold: wvalid=%b required 1", m_axi_wvalid);
                end
            end
            if (b_pend > 0) begin
                if (b_wait >= b_dly) begin
                    m_axi_bvalid = 1; m_axi_bresp = bresp_sel;
                    if (m_axi_bready) begin b_pend--; b_wait = 0; end
                end else begin
                    m_axi_bvalid = 0; b_wait++;
                end
            end else m_axi_bvalid = 0;
            m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (aw_wait >= aw_dly) begin
                    m_axi_awready = 1; aw_wait = 0; aw_cnt++; n_cmp++;
                    if (aw_q.size() == 0) begin
                        n_bad++; $display("FAIL aw_extra: awaddr=%h with no expected beat", m_axi_awaddr);
                    end else if (m_axi_awaddr !== aw_q[0]) begin
                        n_bad++; $display("FAIL awaddr: got %h required %h", m_axi_awaddr, aw_q[0]);
                        void'(aw_q.pop_front());
                    end else void'(aw_q.pop_front());
                end else aw_wait++;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (w_wait >= w_dly) begin
                    m_axi_wready = 1; w_wait = 0; w_cnt++; n_cmp++;
                    if (w_q.size() == 0) begin
                        n_bad++; $display("FAIL w_extra: wdata=%h with no expected beat", m_axi_wdata);
                    end else if (m_axi_wdata !== w_q[0]) begin
                        n_bad++; $display("FAIL wdata: got %h required %h", m_axi_wdata, w_q[0]);
                        void'(w_q.pop_front());
                    end else void'(w_q.pop_front());
                end else w_wait++;
            end
            if (aw_cnt > b_req && w_cnt > b_req) begin b_req++; b_pend++; end
            prev_awv = m_axi_awvalid; prev_awr = m_axi_awready;
            prev_wv = m_axi_wvalid;   prev_wr = m_axi_wready;
        end
    end

    // event monitor: ADDR entry, timeout rise, done count
    int adr_cyc = 0, to_cyc = 0, done_cnt = 0;
    logic [2:0] prev_st = 3'd0;
    bit prev_to = 0;
    always @(negedge i_clk) begin
        if (o_state == 3'd2 && prev_st != 3'd2) adr_cyc = cyc;
        if (o_timeout && !prev_to) to_cyc = cyc;
        if (o_done) done_cnt++;
        prev_st = o_state; prev_to = o_timeout;
    end

    // handler model: one word, optionally with addr/data arriving a cycle late
    task automatic do_write(input logic [39:0] a, input logic [63:0] d, input int lat, input bit late);
        int t0; bit got;
        @(negedge i_clk);
        i_start = 1;
        i_addr = late ? ~a : a;
        i_data = late ? ~d : d;
        aw_q.push_back(a & ~40'h7);
        w_q.push_back(d);
        t0 = cyc; got = 0;
        if (late) begin @(negedge i_clk); i_addr = a; i_data = d; end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge i_clk);
            if (o_done) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL done_wait: no o_done within 200 cycles");
        end else if (cyc - t0 != lat) begin
            n_bad++; $display("FAIL done_latency: got %0d required %0d", cyc - t0, lat);
        end
        i_start = 0;
        @(negedge i_clk);
        n_cmp++;
        if (o_done !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse: o_done=%b in GAP required 0", o_done);
        end
    endtask

    task automatic test_reset();
        i_rst = 0;
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if ({o_state, o_busy, o_done, o_err, o_timeout, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 10'b0
            || m_axi_awaddr !== 40'd0 || m_axi_wdata !== 64'd0) begin
            n_bad++; $display("FAIL reset_state: state=%0d busy=%b done=%b err=%b to=%b awv=%b wv=%b br=%b aw=%h wd=%h required all 0",
                o_state, o_busy, o_done, o_err, o_timeout, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr, m_axi_wdata);
        end
        n_cmp++;
        if (m_axi_awlen !== 8'd0 || m_axi_awsize !== 3'b011 || m_axi_awburst !== 2'b01 || m_axi_awcache !== 4'b0011
            || m_axi_awprot !== 3'd0 || m_axi_wstrb !== 8'hFF || m_axi_wlast !== 1'b1) begin
            n_bad++; $display("FAIL axi_constants: len=%h size=%b burst=%b cache=%b prot=%b strb=%h last=%b required 00 011 01 0011 000 ff 1",
                m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_wstrb, m_axi_wlast);
        end
        i_rst = 1;
        @(negedge i_clk);
    endtask

    task automatic test_zero_wait();
        int d0, a0;
        d0 = done_cnt; a0 = aw_cnt;
        for (int i = 1; i <= 5; i++)
            do_write(40'(i) << 20, 64'hA5A5_0000_0000_0000 | 64'(i * 32'h1111_1111), 5, 0);
        n_cmp++;
        if (done_cnt - d0 != 5 || aw_cnt - a0 != 5) begin
            n_bad++; $display("FAIL five_words: dones=%0d aws=%0d required 5 5", done_cnt - d0, aw_cnt - a0);
        end
        n_cmp++;
        if (o_timeout !== 1'b0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL flags_clean: err=%b timeout=%b required 0 0", o_err, o_timeout);
        end
    endtask

    task automatic test_settle();
        do_write(40'h12_3456_789F, 64'hDEAD_BEEF_0123_4567, 5, 1);
    endtask

    task automatic test_split();
        aw_dly = 0; w_dly = 3;
        do_write(40'h60_0008, 64'h1111_2222_3333_4444, 8, 0);
        aw_dly = 3; w_dly = 0;
        do_write(40'h70_0010, 64'h5555_6666_7777_8888, 8, 0);
        aw_dly = 0;
    endtask

    task automatic test_error();
        do_write(40'h80_0000, 64'h1, 5, 0);
        n_cmp++;
        if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_okay: o_err=%b required 0", o_err); end
        bresp_sel = 2'b10;
        do_write(40'h80_0008, 64'h2, 5, 0);
        bresp_sel = 2'b00;
        n_cmp++;
        if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_set: o_err=%b required 1", o_err); end
        do_write(40'h80_0010, 64'h3, 5, 0);
        n_cmp++;
        if (o_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: o_err=%b required 1", o_err); end
        i_err_clr = 1;
        @(negedge i_clk);
        i_err_clr = 0;
        n_cmp++;
        if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_clr: o_err=%b required 0", o_err); end
    endtask

    task automatic test_timeout();
        b_dly = 20;
        do_write(40'h90_0000, 64'hCAFE_F00D_0000_0001, 25, 0);
        b_dly = 0;
        n_cmp++;
        if (to_cyc - adr_cyc != 8) begin
            n_bad++; $display("FAIL timeout_cycle: set %0d cycles after ADDR required 8", to_cyc - adr_cyc);
        end
        n_cmp++;
        if (o_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: o_timeout=%b required 1", o_timeout); end
        i_err_clr = 1;
        @(negedge i_clk);
        i_err_clr = 0;
        n_cmp++;
        if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_clr: o_timeout=%b required 0", o_timeout); end
    endtask

    task automatic test_abort();
        int a0;
        a0 = aw_cnt;
        @(negedge i_clk);
        i_start = 1; i_addr = 40'hAA_0000; i_data = 64'hBAD;
        @(negedge i_clk);
        i_start = 0;
        repeat (10) @(negedge i_clk);
        n_cmp++;
        if (aw_cnt != a0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL abort: aws=%0d state=%0d busy=%b required 0 0 0", aw_cnt - a0, o_state, o_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        b_dly = 30;
        @(negedge i_clk);
        i_start = 1; i_addr = 40'hB0_0000; i_data = 64'h77;
        aw_q.push_back(40'hB0_0000); w_q.push_back(64'h77);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin @(negedge i_clk); if (o_state == 3'd3) got = 1; end
        repeat (9) @(negedge i_clk);
        n_cmp++;
        if (!got || o_state !== 3'd3 || o_timeout !== 1'b1) begin
            n_bad++; $display("FAIL resp_wait: state=%0d timeout=%b required 3 1", o_state, o_timeout);
        end
        i_rst = 0; i_start = 0;
        #1;
        n_cmp++;
        if ({o_state, o_busy, o_done, o_err, o_timeout, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 10'b0
            || m_axi_awaddr !== 40'd0 || m_axi_wdata !== 64'd0) begin
            n_bad++; $display("FAIL reset_mid: state=%0d busy=%b done=%b err=%b to=%b awv=%b wv=%b br=%b aw=%h wd=%h required all 0",
                o_state, o_busy, o_done, o_err, o_timeout, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr, m_axi_wdata);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1;
        b_dly = 0;
        do_write(40'hC0_0000, 64'h99, 5, 0);
        n_cmp++;
        if (aw_q.size() != 0 || w_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: aw left %0d w left %0d required 0 0", aw_q.size(), w_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_settle();
        test_split();
        test_error();
        test_timeout();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
